lt_compare_arbiter: RTL
=======================

LT_COMPARE_ARBITER -- requirements
Module: lt_compare_arbiter

Interface
REQ-001 Parameter N, default 32: operand width in bits; operands are two's complement.
REQ-002 Parameter NUM_REQ, default 4: number of requesters sharing the one comparator.
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port req_valid, input, NUM_REQ: bit i high means requester i presents an operand pair.
REQ-006 Port req_a, input, NUM_REQ*N: operand a of requester i at bits [i*N +: N].
REQ-007 Port req_b, input, NUM_REQ*N: operand b of requester i at bits [i*N +: N].
REQ-008 Port req_ready, output, NUM_REQ: one-hot grant; bit i high means requester i's operands are captured this cycle.
REQ-009 Port rsp_valid, output, 1: a result is held on rsp_*.
REQ-010 Port rsp_ready, input, 1: the consumer accepts the result this cycle.
REQ-011 Port rsp_id, output, $clog2(NUM_REQ): index of the requester that owns the result.
REQ-012 Port rsp_lt, output, 1: result of a < b, signed.
REQ-013 Port rsp_eq, output, 1: result of a == b.

Function
REQ-014 The FSM SHALL have three states: IDLE, COMPUTE and RESPOND.
REQ-015 IDLE with any req_valid bit high: grant the first valid requester at or after rr_ptr (round-robin, wrapping at NUM_REQ-1 to 0).
- Assert only that bit of req_ready, combinationally, in the same cycle.
- Register its operands and index, then go to COMPUTE.
REQ-016 IDLE with no req_valid bit high: req_ready SHALL be all zeros and the FSM SHALL stay in IDLE.
REQ-017 On a grant, rr_ptr SHALL become (granted index + 1) mod NUM_REQ; otherwise rr_ptr is unchanged.
REQ-018 COMPUTE SHALL drive the registered operands into one comparator_lt instance (a - b via a + ~b + 1, result = N ^ V), register lt and eq, and go to RESPOND after exactly one cycle.
REQ-019 RESPOND SHALL hold rsp_valid=1 and keep rsp_id, rsp_lt and rsp_eq stable until rsp_ready is high; on that edge go to IDLE and clear rsp_valid.
REQ-020 req_ready SHALL be zero in COMPUTE and RESPOND; new requests are not accepted until the FSM returns to IDLE.
REQ-021 Minimum throughput SHALL be one result per 3 cycles (grant, compute, respond with rsp_ready already high).
REQ-022 A requester that drops req_valid before it is granted SHALL lose its pending request; the arbiter keeps no request memory.
REQ-023 Signed boundary cases SHALL be exact:
- a = 0x80000000, b = 0x7FFFFFFF gives lt=1.
- a = 0x7FFFFFFF, b = 0x80000000 gives lt=0.
- a == b gives lt=0 and eq=1.
REQ-024 rsp_eq SHALL be computed as equality of the registered operands and SHALL NOT rely on the adder carry.

Reset
REQ-025 While rst is high, with no clock needed:
- state=IDLE, rr_ptr=0
- rsp_valid=0, rsp_id=0, rsp_lt=0, rsp_eq=0
- req_ready=0
REQ-026 Reset asserted mid-transaction (COMPUTE or RESPOND) SHALL discard the transaction with no response; the first grant after release starts from requester 0.

Configuration
REQ-027 Macro LT_ARB_STATS_EN defined: add output port done_count, 16 bits.
- Reset value 0.
- Increments on each RESPOND handshake (rsp_valid & rsp_ready).
- Saturates at 0xFFFF.
REQ-028 Macro LT_ARB_STATS_EN undefined: the done_count port and its counter SHALL be absent; all other behaviour is identical.

Verification
REQ-029 Reset, then req_valid[0]=1 with a=-5, b=3, rsp_ready=1 -> req_ready=0001 in cycle 0; rsp_valid in cycle 2 with rsp_id=0, lt=1, eq=0.
REQ-030 All four req_valid held high with rsp_ready=1 -> grant order 0,1,2,3,0; each grant exactly 3 cycles after the previous one.
REQ-031 Overflow pairs (0x80000000 vs 0x7FFFFFFF; 0x7FFFFFFF vs 0x80000000; 0x80000000 vs 0x80000000) -> lt = 1, 0, 0; eq = 0, 0, 1.
REQ-032 Hold rsp_ready=0 for 5 cycles in RESPOND with req_valid=1111 -> outputs stable; req_ready=0 throughout; next grant on the cycle after rsp_ready rises.
REQ-033 Assert rst during COMPUTE for a request from requester 2 -> no rsp_valid pulse; next grant after release goes to requester 0 when requesters 0 and 2 are both valid.
REQ-034 With LT_ARB_STATS_EN: 70000 back-to-back transactions -> done_count = 0xFFFF; reset clears it to 0.

Source files
------------

// File: rtl/lt_compare_arbiter.sv
// ---------------------------------------------------------------------------
// lt_compare_arbiter
//   Round-robin arbiter that shares one signed less-than / equality comparator
//   between NUM_REQ requesters. One transaction is handled at a time:
//   IDLE (grant + operand capture) -> COMPUTE (compare) -> RESPOND (hold the
//   result until the consumer accepts it).
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : [NUM_REQ]   requester i presents an operand pair
//   req_a      : [NUM_REQ*N] operand a of requester i at [i*N +: N]
//   req_b      : [NUM_REQ*N] operand b of requester i at [i*N +: N]
//   req_ready  : [NUM_REQ]   one-hot grant, combinational in IDLE
//   rsp_valid  : result held on rsp_*
//   rsp_ready  : consumer accepts the result
//   rsp_id     : index of the requester owning the result
//   rsp_lt     : signed a < b
//   rsp_eq     : a == b
//   done_count : [16] saturating count of completed responses
//                (present only when LT_ARB_STATS_EN is defined)
//
// Build option
//   LT_ARB_STATS_EN : adds the done_count statistics output.
// ---------------------------------------------------------------------------

module comparator_lt #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic                lt_o,
  output logic                eq_o
);
  logic [N-1:0] diff;
  logic         ovf;

  always_comb begin
    diff = a_i + ~b_i + N'(1);
    // Subtraction overflows only when the operand signs differ and the
    // difference takes the sign of b; lt is then the inverted sign bit.
    ovf  = (a_i[N-1] ^ b_i[N-1]) & (diff[N-1] ^ a_i[N-1]);
    lt_o = diff[N-1] ^ ovf;
    // Equality is a direct compare so it never depends on the adder carry.
    eq_o = (a_i == b_i);
  end
endmodule

module lt_compare_arbiter #(
  parameter  int N       = 32,
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*N-1:0] req_a,
  input  logic [NUM_REQ*N-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [ID_W-1:0]      rsp_id,
  output logic                 rsp_lt,
  output logic                 rsp_eq
`ifdef LT_ARB_STATS_EN
  ,
  output logic [15:0]          done_count
`endif
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] RESPOND = 2'd2;

  logic [1:0]             state_q, state_d;
  logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic signed [N-1:0]    a_q, b_q;
  logic [ID_W-1:0]        own_id_q;
  logic                   rsp_valid_q, rsp_lt_q, rsp_eq_q;
  logic [ID_W-1:0]        rsp_id_q;

  logic                   gnt_found;
  logic [ID_W-1:0]        gnt_idx;
  logic [ID_W-1:0]        cand;
  logic                   grant_en;
  logic                   cmp_lt, cmp_eq;

  // Round-robin search: first valid requester at or after rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      if (!gnt_found && req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Gated by rst so the grant is low while reset is held, clock or not.
  assign grant_en  = (state_q == IDLE) && gnt_found && !rst;
  assign req_ready = grant_en ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (grant_en) begin
          state_d  = COMPUTE;
          rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      COMPUTE: state_d = RESPOND;
      RESPOND: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  comparator_lt #(.N(N)) u_cmp (
    .a_i  (a_q),
    .b_i  (b_q),
    .lt_o (cmp_lt),
    .eq_o (cmp_eq)
  );

  // Stage boundary: grant captures operands and owner index.
  always_ff @(posedge clk) begin
    if (grant_en) begin
      a_q      <= req_a[gnt_idx*N +: N];
      b_q      <= req_b[gnt_idx*N +: N];
      own_id_q <= gnt_idx;
    end
  end

  // Stage boundary: compare result registered into the response holder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_lt_q    <= 1'b0;
      rsp_eq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      if (state_q == COMPUTE) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= own_id_q;
        rsp_lt_q    <= cmp_lt;
        rsp_eq_q    <= cmp_eq;
      end else if ((state_q == RESPOND) && rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_lt    = rsp_lt_q;
  assign rsp_eq    = rsp_eq_q;

`ifdef LT_ARB_STATS_EN
  logic [15:0] done_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done_count_q <= '0;
    end else if (rsp_valid_q && rsp_ready && (done_count_q != 16'hFFFF)) begin
      done_count_q <= done_count_q + 16'd1;
    end
  end

  assign done_count = done_count_q;
`endif

endmodule
